counter: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/counter_prescaler.sv | 40 ++++
 rtl/counter.sv | 76 +++++++
 tb/tb_counter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module   : pwm_pkg
// Brief    : Shared widths and direction constants for the PWM block set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

  localparam int PERIOD_W   = 16;
  localparam int PRESCALE_W = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/counter_prescaler.sv
//------------------------------------------------------------------------------
// Module   : prescaler
// Brief    : Enable-gated clock divider; tick fires every prescale+1 enabled edges.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prescaler
  import pwm_pkg::*;
#(
  parameter int PSC_W = PRESCALE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] r_psc_cnt;
  logic             w_tick;

  // >= rather than == so a live reduction of prescale ticks at once
  assign w_tick = en && (r_psc_cnt >= prescale);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc_cnt <= '0;
    end else if (clr || w_tick) begin
      r_psc_cnt <= '0;
    end else if (en) begin
      r_psc_cnt <= r_psc_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter.sv
//------------------------------------------------------------------------------
// Module   : counter
// Brief    : Prescaled up/down timebase counter with one-cycle wrap pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PERIOD_W,
  parameter int PSC_W = PRESCALE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic             upnotdown,
  input  logic [PSC_W-1:0] prescale,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] counter_val,
  output logic             wrap
);

  logic             w_tick;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (count_reset),
    .prescale (prescale),
    .tick     (w_tick)
  );

  // Out-of-range counts (period lowered live) wrap on the next tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (count_reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (w_tick) begin
      if (upnotdown == DIR_UP) begin
        if (r_count >= period) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
          r_wrap  <= 1'b0;
        end
      end else begin
        if ((r_count == '0) || (r_count > period)) begin
          r_count <= period;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count - 1'b1;
          r_wrap  <= 1'b0;
        end
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign counter_val = r_count;
  assign wrap        = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
//------------------------------------------------------------------------------
// Module   : tb_counter
// Brief    : Directed + randomized bench for counter against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        count_reset;
  logic        upnotdown;
  logic [7:0]  prescale;
  logic [15:0] period;
  logic [15:0] counter_val;
  logic        wrap;

  int n_cmp;
  int n_bad;

  int          m_phase;
  logic [15:0] m_val;
  logic        m_wrap;

  counter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .count_reset (count_reset),
    .upnotdown   (upnotdown),
    .prescale    (prescale),
    .period      (period),
    .counter_val (counter_val),
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One enabled edge per elapsed count of prescale+1; the count then moves
  // one step along the ring 0..period in the selected direction.
  task automatic model_edge();
    if (count_reset) begin
      m_val = 0; m_phase = 0; m_wrap = 0;
    end else if (en) begin
      if (m_phase >= int'(prescale)) begin
        m_phase = 0;
        if (upnotdown) begin
          m_wrap = (m_val >= period);
          m_val  = m_wrap ? 16'd0 : 16'(m_val + 1);
        end else begin
          m_wrap = (m_val == 0) || (m_val > period);
          m_val  = m_wrap ? period : 16'(m_val - 1);
        end
      end else begin
        m_phase++;
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("counter_val", 32'(counter_val), 32'(m_val));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear();
    count_reset = 1'b1;
    step();
    count_reset = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_up [8];
    logic [15:0] exp_dn [7];
    n_cmp = 0; n_bad = 0;
    m_phase = 0; m_val = 0; m_wrap = 0;
    rst_n = 1'b0; en = 1'b0; count_reset = 1'b0; upnotdown = 1'b1;
    prescale = 8'd0; period = 16'd3;
    #12;
    check("reset counter_val", 32'(counter_val), 32'd0);
    check("reset wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up count, period 3, one-cycle latency
    exp_up = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("up seq", 32'(counter_val), 32'(exp_up[i]));
      check("up seq wrap", 32'(wrap), 32'(exp_up[i] == 0));
    end

    // Prescale 2 with enable drop mid-hold
    clear();
    prescale = 8'd2; period = 16'h00FF;
    steps(7);
    en = 1'b0;
    steps(4);
    en = 1'b1;
    steps(8);

    // Down count, period 5
    prescale = 8'd0; period = 16'd5; upnotdown = 1'b0;
    clear();
    exp_dn = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd5};
    for (int i = 0; i < 7; i++) begin
      step();
      check("down seq", 32'(counter_val), 32'(exp_dn[i]));
      check("down seq wrap", 32'(wrap), 32'(i == 0 || i == 6));
    end

    // Live period reduction below current count
    upnotdown = 1'b1; period = 16'h00FF;
    clear();
    steps(16);
    check("preload 0x10", 32'(counter_val), 32'h10);
    period = 16'h0008;
    step();
    check("shrink wraps", 32'(counter_val), 32'd0);
    check("shrink wrap", 32'(wrap), 32'd1);
    steps(4);

    // Clear at 0x1234, enabled and disabled
    upnotdown = 1'b0; period = 16'h1234;
    clear();
    step();
    check("at 0x1234", 32'(counter_val), 32'h1234);
    clear();
    check("clear en=1", 32'(counter_val), 32'd0);
    step();
    en = 1'b0;
    clear();
    check("clear en=0", 32'(counter_val), 32'd0);
    en = 1'b1;

    // Full-range top, then async reset between edges
    period = 16'hFFFF;
    clear();
    steps(2);
    check("top preload", 32'(counter_val), 32'hFFFE);
    upnotdown = 1'b1;
    steps(2);
    check("full-range wrap", 32'(counter_val), 32'h0000);
    check("full-range wrap flag", 32'(wrap), 32'd1);
    steps(3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset value", 32'(counter_val), 32'd0);
    check("async reset wrap", 32'(wrap), 32'd0);
    m_val = 0; m_phase = 0; m_wrap = 0;
    #1 rst_n = 1'b1;
    steps(3);

    // Period 0 in both directions
    period = 16'd0;
    steps(3);
    upnotdown = 1'b0;
    steps(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(0, 7) != 0);
      count_reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) upnotdown = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 63) == 0) prescale  = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) period    = 16'($urandom_range(0, 12));
      step();
    end
    count_reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
